systolic_mm_engine: RTL and testbench
=====================================

# systolic_mm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine, successor to the fixed 3×3 8-bit array. It computes C = A·B for A (N×K) and B (K×N), with K set per job at runtime, and streams K operand beats through a valid/ready handshake. Input skewing, bubble tolerance, optional saturation and a job-level start/done protocol are internal. It sits between the operand buffer reader and the result writer.

## Interface
- N, default 3: array dimension (rows of A / columns of B), 2..16.
- DW, default 8: unsigned operand width.
- ACCW, default 16: unsigned accumulator / result element width, ≥ 2·DW.
- KW, default 8: width of k_len.
- SAT, default 0: 1 = accumulators saturate at 2^ACCW−1; 0 = wrap modulo 2^ACCW.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  job request, sampled in IDLE only.
- k_len  in  KW  inner dimension K, sampled with start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat this cycle.
- a_in  in  N·DW  column k of A: lane i = A[i][k] at [i·DW +: DW].
- b_in  in  N·DW  row k of B: lane j = B[k][j] at [j·DW +: DW].
- busy  out  1  high in any state other than IDLE.
- c_valid  out  1  results in c are final.
- c_ready  in  1  consumer accepts results.
- c  out  N·N·ACCW  row-major, C[i][j] at [(i·N+j)·ACCW +: ACCW].
- ovf  out  1  sticky: an accumulator overflowed (saturated or wrapped) during the current job.

## Operation
- FSM states: IDLE, FEED, FLUSH, DONE.
- IDLE: in_ready=0. start=1 → clears all accumulators, skew and PE pipeline registers, ovf, beat counter; latches k_len; next state FEED, or FLUSH if k_len=0.
- FEED: in_ready=1. Beat accepted when in_valid&&in_ready; counter increments. Accepting beat number k_len → FLUSH. Cycles with in_valid=0 inject zero operands into the skew front (bubble); results unaffected.
- FLUSH: in_ready=0, zeros injected; lasts exactly 2N−1 cycles (counter), then DONE.
- DONE: c_valid=1, c stable. c_ready=1 → IDLE next cycle. c keeps last values in IDLE until next start clears them.
- Skew: lane i of a_in delayed by i registers before entering row i; lane j of b_in delayed by j registers before column j. PE(i,j) forwards a right and b down one register per cycle and accumulates a·b.
- Arithmetic: product is 2·DW bits zero-extended to ACCW+1 for the add; carry out sets ovf. SAT=1 clamps to all-ones; SAT=0 keeps low ACCW bits.
- start outside IDLE ignored; k_len changes outside IDLE ignored.

## Timing
- Reset (rst=0, asynchronous): state IDLE, in_ready=0, busy=0, c_valid=0, ovf=0, c=0, all pipeline/skew registers 0. Reset mid-job aborts immediately; no partial result is flagged.
- start sampled at edge t → busy=1 and in_ready=1 from t+1.
- Beat accepted at edge t contributes to C[i][j] by end of edge t+i+j+1.
- Job latency with no bubbles: start edge t0, beats at t0+1..t0+K, FLUSH t0+K+1..t0+K+2N−1, c_valid=1 from t0+K+2N.
- Bubbles extend FEED by one cycle each; FLUSH length unchanged.
- c_valid&&c_ready at edge t → c_valid=0, busy=0 at t+1; next start accepted at t+1 edge.
- Throughput: one beat per cycle in FEED; no overlap between jobs.

## Test plan
- Basic 3×3 (N=3, DW=8, ACCW=16, K=3): beats (a=1,4,7 b=1,2,3), (2,5,8 / 4,5,6), (3,6,9 / 7,8,9) back-to-back -> c_valid at start+9; C = 30,36,42,66,81,96,102,126,150; ovf=0.
- Bubbles: same operands with in_valid low for 2 cycles between each beat -> identical C, c_valid at start+13.
- Overflow: all operands 255, K=3 -> SAT=1: every C = 65535, ovf=1; SAT=0: every C = 64003, ovf=1.
- Back-to-back jobs: job1 as basic, hold c_ready low 5 cycles (c stable), then job2 A=identity, B=basic B -> C = 1,2,3,4,5,6,7,8,9, no residue from job1.
- Reset mid-FEED after 2 beats -> all outputs 0 within same cycle; fresh basic job afterwards yields basic result. Also k_len=0 -> all C=0, c_valid at start+6.
- Parametric: N=4, K=5, random 8-bit operands with random in_valid -> C matches reference model; start pulses during FEED/FLUSH/DONE ignored.

Source files
------------

// File: rtl/systolic_mm_engine_if.sv
// Operand, job-control and result bundle between the buffer reader, the
// systolic engine and the result writer.
interface systolic_mm_engine_if #(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 16,
  parameter int KW   = 8
);
  logic                start;
  logic [KW-1:0]       k_len;
  logic                in_valid;
  logic                in_ready;
  logic [N*DW-1:0]     a_in;
  logic [N*DW-1:0]     b_in;
  logic                busy;
  logic                c_valid;
  logic                c_ready;
  logic [N*N*ACCW-1:0] c;
  logic                ovf;

  modport master (
    output start, k_len, in_valid, a_in, b_in, c_ready,
    input  in_ready, busy, c_valid, c, ovf
  );

  modport slave (
    input  start, k_len, in_valid, a_in, b_in, c_ready,
    output in_ready, busy, c_valid, c, ovf
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic matrix multiplier: streams K operand beats,
// skews them into the array, flushes, then holds C until the consumer accepts.
module systolic_mm_engine #(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 16,
  parameter int KW   = 8,
  parameter int SAT  = 0
) (
  input logic                 clk,
  input logic                 rst,
  systolic_mm_engine_if.slave bus
);
  localparam int CW = (KW > 6) ? KW : 6;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t                state, state_next;
  logic [KW-1:0]         k_reg;
  logic [CW-1:0]         cnt;
  logic                  ovf_q;
  logic                  clear;
  logic                  accept;
  logic                  acc_en;
  logic                  last_beat;
  logic [N*DW-1:0]       row_a;
  logic [N*DW-1:0]       col_b;
  logic [N*N-1:0]        carry;
  logic [N*(N-1)*DW-1:0] a_fwd;
  logic [N*(N-1)*DW-1:0] b_fwd;

  assign accept    = bus.in_valid && (state == FEED);
  assign last_beat = (cnt + CW'(1)) == CW'(k_reg);
  assign acc_en    = (state == FEED) || (state == FLUSH);
  assign bus.ovf   = ovf_q;

  always_comb begin
    state_next   = state;
    clear        = 1'b0;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    bus.c_valid  = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          clear      = 1'b1;
          state_next = (bus.k_len == '0) ? FLUSH : FEED;
        end
      end
      FEED: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && last_beat) state_next = FLUSH;
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) state_next = DONE;
      end
      DONE: begin
        bus.c_valid = 1'b1;
        if (bus.c_ready) state_next = IDLE;
      end
    endcase
  end

  // cnt counts accepted beats in FEED, then the 2N-1 drain cycles in FLUSH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k_reg <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        k_reg <= bus.k_len;
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (accept) cnt <= last_beat ? '0 : cnt + CW'(1);
        else if (state == FLUSH) cnt <= cnt + CW'(1);
        if (acc_en && (|carry)) ovf_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_lane, b_lane;

    // idle cycles push zeros into the skew front so bubbles add nothing
    assign a_lane = accept ? bus.a_in[i*DW +: DW] : '0;
    assign b_lane = accept ? bus.b_in[i*DW +: DW] : '0;

    if (i == 0) begin : g_noskew
      assign row_a[DW-1:0] = a_lane;
      assign col_b[DW-1:0] = b_lane;
    end else begin : g_skew
      logic [DW-1:0] a_sk [i];
      logic [DW-1:0] b_sk [i];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) begin
            a_sk[k] <= '0;
            b_sk[k] <= '0;
          end
        end else if (clear) begin
          for (int k = 0; k < i; k++) begin
            a_sk[k] <= '0;
            b_sk[k] <= '0;
          end
        end else begin
          a_sk[0] <= a_lane;
          b_sk[0] <= b_lane;
          for (int k = 1; k < i; k++) begin
            a_sk[k] <= a_sk[k-1];
            b_sk[k] <= b_sk[k-1];
          end
        end
      end

      assign row_a[i*DW +: DW] = a_sk[i-1];
      assign col_b[i*DW +: DW] = b_sk[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0]   a_w, b_n;
      logic [2*DW-1:0] prod;
      logic [ACCW:0]   sum;
      logic [ACCW-1:0] acc_q;

      if (j == 0) begin : g_aedge
        assign a_w = row_a[i*DW +: DW];
      end else begin : g_ain
        assign a_w = a_fwd[(i*(N-1)+j-1)*DW +: DW];
      end

      if (i == 0) begin : g_bedge
        assign b_n = col_b[j*DW +: DW];
      end else begin : g_bin
        assign b_n = b_fwd[((i-1)*N+j)*DW +: DW];
      end

      // one extra sum bit exposes the carry that drives ovf and saturation
      assign prod = {{DW{1'b0}}, a_w} * {{DW{1'b0}}, b_n};
      assign sum  = {1'b0, acc_q} + (ACCW+1)'(prod);
      assign carry[i*N+j] = sum[ACCW];
      assign bus.c[(i*N+j)*ACCW +: ACCW] = acc_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)        acc_q <= '0;
        else if (clear)  acc_q <= '0;
        else if (acc_en) acc_q <= ((SAT != 0) && sum[ACCW]) ? '1 : sum[ACCW-1:0];
      end

      if (j < N - 1) begin : g_afwd
        logic [DW-1:0] a_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)       a_q <= '0;
          else if (clear) a_q <= '0;
          else            a_q <= a_w;
        end
        assign a_fwd[(i*(N-1)+j)*DW +: DW] = a_q;
      end

      if (i < N - 1) begin : g_bfwd
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)       b_q <= '0;
          else if (clear) b_q <= '0;
          else            b_q <= b_n;
        end
        assign b_fwd[(i*N+j)*DW +: DW] = b_q;
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Drives a 3x3 wrapping, a 3x3 saturating and a 4x4 engine in lockstep and
// compares results, latency and ovf against plain matrix arithmetic.
module tb_systolic_mm_engine;
  localparam int DW   = 8;
  localparam int ACCW = 16;
  localparam int KW   = 8;
  localparam int MAXK = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, in_valid, c_ready;
  logic [KW-1:0] k_len;
  logic [4*DW-1:0] a_drv, b_drv;

  int tests_run = 0;
  int tests_failed = 0;
  int unsigned     mat_a [4][MAXK];
  int unsigned     mat_b [MAXK][4];
  longint unsigned ref_c [4][4];

  always #5 clk = ~clk;

  systolic_mm_engine_if #(.N(3), .DW(DW), .ACCW(ACCW), .KW(KW)) if3w ();
  systolic_mm_engine_if #(.N(3), .DW(DW), .ACCW(ACCW), .KW(KW)) if3s ();
  systolic_mm_engine_if #(.N(4), .DW(DW), .ACCW(ACCW), .KW(KW)) if4 ();

  assign if3w.start = start;     assign if3s.start = start;     assign if4.start = start;
  assign if3w.k_len = k_len;     assign if3s.k_len = k_len;     assign if4.k_len = k_len;
  assign if3w.in_valid = in_valid; assign if3s.in_valid = in_valid; assign if4.in_valid = in_valid;
  assign if3w.c_ready = c_ready; assign if3s.c_ready = c_ready; assign if4.c_ready = c_ready;
  assign if3w.a_in = a_drv[3*DW-1:0]; assign if3s.a_in = a_drv[3*DW-1:0]; assign if4.a_in = a_drv;
  assign if3w.b_in = b_drv[3*DW-1:0]; assign if3s.b_in = b_drv[3*DW-1:0]; assign if4.b_in = b_drv;

  systolic_mm_engine #(.N(3), .DW(DW), .ACCW(ACCW), .KW(KW), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(if3w));
  systolic_mm_engine #(.N(3), .DW(DW), .ACCW(ACCW), .KW(KW), .SAT(1)) u_sat  (.clk(clk), .rst(rst), .bus(if3s));
  systolic_mm_engine #(.N(4), .DW(DW), .ACCW(ACCW), .KW(KW), .SAT(0)) u_big  (.clk(clk), .rst(rst), .bus(if4));

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void clearMats();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < MAXK; k++) begin
        mat_a[i][k] = 0;
        mat_b[k][i] = 0;
      end
  endfunction

  function automatic void setBasic();
    clearMats();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        mat_a[i][k] = i * 3 + k + 1;
        mat_b[k][i] = k * 3 + i + 1;
      end
  endfunction

  function automatic void computeRef(input int k);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ref_c[i][j] = 0;
        for (int kk = 0; kk < k; kk++)
          ref_c[i][j] += longint'(mat_a[i][kk]) * longint'(mat_b[kk][j]);
      end
  endfunction

  task automatic checkResults(input string tag);
    bit ovf3 = 1'b0;
    bit ovf4 = 1'b0;
    longint unsigned r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        r = ref_c[i][j];
        if (r > 65535) begin
          ovf4 = 1'b1;
          if (i < 3 && j < 3) ovf3 = 1'b1;
        end
        checkOutput($sformatf("%s c4[%0d][%0d]", tag, i, j), 64'(if4.c[(i*4+j)*ACCW +: ACCW]), r & 64'hFFFF);
        if (i < 3 && j < 3) begin
          checkOutput($sformatf("%s c3w[%0d][%0d]", tag, i, j), 64'(if3w.c[(i*3+j)*ACCW +: ACCW]), r & 64'hFFFF);
          checkOutput($sformatf("%s c3s[%0d][%0d]", tag, i, j), 64'(if3s.c[(i*3+j)*ACCW +: ACCW]),
                      (r > 65535) ? 64'd65535 : r);
        end
      end
    checkOutput({tag, " ovf3w"}, 64'(if3w.ovf), 64'(ovf3));
    checkOutput({tag, " ovf3s"}, 64'(if3s.ovf), 64'(ovf3));
    checkOutput({tag, " ovf4"}, 64'(if4.ovf), 64'(ovf4));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy4"}, 64'(if4.busy), 0);
    checkOutput({tag, " in_ready4"}, 64'(if4.in_ready), 0);
    checkOutput({tag, " c_valid4"}, 64'(if4.c_valid), 0);
    checkOutput({tag, " ovf4"}, 64'(if4.ovf), 0);
    checkOutput({tag, " busy3w"}, 64'(if3w.busy), 0);
    checkOutput({tag, " ovf3s"}, 64'(if3s.ovf), 0);
    checkOutput({tag, " c4_nonzero"}, 64'(|if4.c), 0);
    checkOutput({tag, " c3w_nonzero"}, 64'(|if3w.c), 0);
    checkOutput({tag, " c3s_nonzero"}, 64'(|if3s.c), 0);
  endtask

  // mode 0: back-to-back beats, 1: two idle cycles after each beat, 2: random idles
  task automatic applyStimulus(input string tag, input int k, input int mode, input bit poke);
    int cyc = 1;
    int beat = 0;
    int last_cyc = 0;
    int gap = 0;
    int fv3 = -1;
    int fv4 = -1;
    computeRef(k);
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); in_valid = 1'b0; c_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; k_len = KW'($urandom);
    checkOutput({tag, " busy_after_start"}, 64'(if4.busy), 1);
    while (beat < k && cyc < 400) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else in_valid = !(mode == 2 && $urandom_range(0, 2) == 0);
      if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          a_drv[i*DW +: DW] = DW'(mat_a[i][beat]);
          b_drv[i*DW +: DW] = DW'(mat_b[beat][i]);
        end
      end else begin
        a_drv = $urandom;
        b_drv = $urandom;
      end
      start = poke && ($urandom_range(0, 3) == 0);
      if (in_valid && if4.in_ready) begin
        beat++;
        last_cyc = cyc;
        if (mode == 1) gap = 2;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; a_drv = '0; b_drv = '0;
    for (int w = 0; w < 400 && fv4 < 0; w++) begin
      if (fv3 < 0 && if3w.c_valid) fv3 = cyc;
      if (if4.c_valid) fv4 = cyc;
      if (fv4 < 0) begin
        start = poke && ($urandom_range(0, 3) == 0);
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " latency3"}, 64'(fv3), 64'(last_cyc + 6));
    checkOutput({tag, " latency4"}, 64'(fv4), 64'(last_cyc + 8));
    repeat (5) begin
      start = poke && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput({tag, " c_valid3s_held"}, 64'(if3s.c_valid), 1);
    checkResults({tag, " held"});
    c_ready = 1'b1;
    @(negedge clk);
    c_ready = 1'b0;
    checkOutput({tag, " c_valid4_after_ack"}, 64'(if4.c_valid), 0);
    checkOutput({tag, " busy4_after_ack"}, 64'(if4.busy), 0);
    checkOutput({tag, " busy3w_after_ack"}, 64'(if3w.busy), 0);
    checkResults({tag, " idle"});
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; c_ready = 1'b0;
    a_drv = '0; b_drv = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b1;

    setBasic();
    applyStimulus("basic", 3, 0, 1'b0);
    applyStimulus("bubbles", 3, 1, 1'b0);

    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) begin
        mat_a[i][k] = 255;
        mat_b[k][i] = 255;
      end
    applyStimulus("overflow", 3, 0, 1'b0);

    setBasic();
    applyStimulus("job1", 3, 0, 1'b1);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) mat_a[i][k] = (i == k) ? 1 : 0;
    applyStimulus("job2_identity", 3, 0, 1'b0);

    setBasic();
    @(negedge clk);
    start = 1'b1; k_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        a_drv[i*DW +: DW] = DW'(mat_a[i][b]);
        b_drv[i*DW +: DW] = DW'(mat_b[b][i]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkResetState("midfeed_reset");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("after_reset", 3, 0, 1'b0);

    applyStimulus("k_zero", 0, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int k;
      k = (t == 0) ? 5 : int'($urandom_range(1, 12));
      clearMats();
      for (int i = 0; i < 4; i++)
        for (int kk = 0; kk < k; kk++) begin
          mat_a[i][kk] = $urandom_range(0, 255);
          mat_b[kk][i] = $urandom_range(0, 255);
        end
      applyStimulus($sformatf("random%0d_k%0d", t, k), k, 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
